// File: rtl/button_debounce.sv
// Four-channel push-button debouncer with press/release pulses.
// Optional long-press detection is enabled by defining BUTTON_HOLD_EN.
module button_debounce #(
  parameter int DB_BITS   = 16,
  parameter int HOLD_BITS = 24
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [3:0] button_in,
  output logic [3:0] db_out,
  output logic [3:0] press,
  output logic [3:0] release_pulse,
  output logic [3:0] held
);

  logic [3:0]         s1;
  logic [3:0]         s2;
  logic [DB_BITS-1:0] cnt [4];
  logic [3:0]         flip;

  // A channel flips once the mismatch has survived a full counter span.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 4; i++)
      flip[i] = (s2[i] != db_out[i]) && (&cnt[i]);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1            <= '0;
      s2            <= '0;
      db_out        <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      s1            <= button_in;
      s2            <= s1;
      db_out        <= db_out ^ flip;
      press         <= flip & s2;
      release_pulse <= flip & ~s2;
      for (int i = 0; i < 4; i++) begin
        if ((s2[i] == db_out[i]) || flip[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + DB_BITS'(1);
      end
    end
  end

`ifdef BUTTON_HOLD_EN
  logic [HOLD_BITS-1:0] hcnt  [4];
  logic [HOLD_BITS-1:0] hnext [4];

  always_comb begin
    for (int i = 0; i < 4; i++)
      hnext[i] = hcnt[i] + HOLD_BITS'(1);
  end

  // The hold count restarts on any edge where db_out is low or changing.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      held <= '0;
      for (int i = 0; i < 4; i++)
        hcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!db_out[i] || flip[i]) begin
          hcnt[i] <= '0;
          held[i] <= 1'b0;
        end else if (!(&hcnt[i])) begin
          hcnt[i] <= hnext[i];
          if (&hnext[i])
            held[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign held = '0;
`endif

endmodule
